interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Collects per-source interrupt factor flags (clock timer, stopwatch, K0 and K1 input groups, serial, programmable timer) and gates them with per-source masks and the CPU interrupt-enable flag.
- Arbitrates among the survivors by fixed priority and hands one request to the CPU core through a req/ack handshake with a vector address.
- Sits between the peripheral factor-flag producers (including the input-line factor logic) and the CPU core's interrupt entry sequencer.
- Provides a wake signal for HALT.

Parameters:
- NUM_SOURCES, 6, number of interrupt sources. Index 0 has the highest priority.
- VECTOR_BASE, 12'h102, program address of the source 0 vector.
- VECTOR_STRIDE, 2, address step between consecutive source vectors.
- HOLDOFF_CYCLES, 4, idle cycles enforced after each ack before arbitration resumes. Range 1..15.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- factor_flags  input  NUM_SOURCES  level-held pending flags from peripherals; the peripherals clear them
- irq_mask  input  NUM_SOURCES  1 = source enabled
- int_enable  input  1  CPU interrupt flag (I)
- instr_boundary  input  1  1-cycle pulse when the CPU finishes an instruction and can take an interrupt
- int_req  output  1  interrupt request to CPU
- int_vector  output  12  vector address, valid while int_req=1
- int_source  output  3  index of the granted source, valid while int_req=1
- int_ack  input  1  CPU accepted the request (1-cycle pulse)
- wake  output  1  any enabled source pending (ignores int_enable); used to exit HALT
- busy  output  1  controller not in IDLE

Behaviour:
- Reset:
  - Reset is asynchronous: reset_n low forces state IDLE, int_req=0, int_vector=0, int_source=0, holdoff counter=0 and busy=0 immediately.
  - wake is combinational from its inputs.
  - Reset asserted in any state aborts the operation; no ack is expected afterwards.
- Masking:
  - eligible = factor_flags & irq_mask.
  - wake = |eligible, combinational, independent of state.
- Priority:
  - The winner is the lowest index set in eligible.
  - int_vector = VECTOR_BASE + VECTOR_STRIDE*winner, computed at 12 bits; wrap-around above 12'hFFF is discarded.
- State IDLE:
  - Move to ARB when int_enable=1, |eligible=1 and instr_boundary=1 in the same cycle. Otherwise stay.
- State ARB (1 cycle):
  - Register winner into int_source and int_vector.
  - Next cycle is REQ, with int_req=1 registered.
  - First request latency: instr_boundary in cycle N gives int_req=1 in cycle N+2.
- State REQ:
  - int_req=1; int_vector and int_source are held stable until the request ends.
  - If int_ack=1, go to HOLDOFF and drop int_req next cycle. Load the counter with HOLDOFF_CYCLES.
  - Cancel: if int_enable=0, or the latched source is no longer eligible, go to IDLE and drop int_req next cycle.
  - If int_ack and a cancel condition occur in the same cycle, ack wins.
  - A higher-priority source becoming eligible during REQ does not preempt. The latched request stands.
- State HOLDOFF:
  - The counter decrements each cycle. At 0, go to IDLE.
  - int_req=0. instr_boundary is ignored.
  - This window lets the service routine clear the factor flag and the CPU clear I.
- Other rules:
  - busy = (state != IDLE).
  - int_ack outside REQ is ignored.
  - NUM_SOURCES above 8 is not supported; int_source width is 3.
- After HOLDOFF, a flag that is still eligible with int_enable=1 re-requests at the next instr_boundary. No request is lost and none is duplicated within a single ack.

Test Plan:
- Single source: factor_flags=6'b000100, irq_mask=6'b111111, int_enable=1, instr_boundary pulse at cycle 10 -> int_req=1 at cycle 12, int_source=2, int_vector=12'h106. int_ack at cycle 14 -> int_req=0 at cycle 15, busy=0 at cycle 19.
- Priority: factor_flags=6'b101010, all unmasked -> int_source=1, int_vector=12'h104. After ack, clear bit 1 and wait for holdoff -> next request int_source=3, int_vector=12'h108.
- Masking and wake: factor_flags=6'b000001, irq_mask=6'b000000 -> wake=0, no int_req. Set irq_mask=1 with int_enable=0 -> wake=1, int_req stays 0 for 50 cycles including instr_boundary pulses.
- Cancel: a request is pending in REQ and int_enable drops -> int_req=0 next cycle, state IDLE, no holdoff. In a separate run, int_ack arrives in the same cycle as the int_enable drop -> HOLDOFF entered.
- No preemption: source 4 in REQ, then source 0 asserts -> int_source stays 4 until ack. Source 0 is granted at the first instr_boundary after holdoff.
- Async reset: reset_n pulled low mid-REQ, between clock edges -> int_req=0 and int_vector=0 immediately. After release with flags still set, the next instr_boundary produces a fresh request 2 cycles later.

Source files
------------

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Purpose:
//   Gathers level-held interrupt factor flags from the peripherals, gates
//   them with per-source masks and the CPU interrupt-enable flag, picks one
//   by fixed priority (index 0 highest) and presents it to the CPU core with
//   a req/ack handshake and a vector address. After every ack the controller
//   stays quiet for a few cycles so the service routine can clear the flag
//   and the CPU can clear I before arbitration resumes.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   factor_flags   pending flags from peripherals (peripherals clear them)
//   irq_mask       per-source enable, 1 = enabled
//   int_enable     CPU interrupt flag (I)
//   instr_boundary 1-cycle pulse when the CPU can take an interrupt
//   int_req        interrupt request to the CPU
//   int_vector     vector address of the granted source, valid with int_req
//   int_source     index of the granted source, valid with int_req
//   int_ack        1-cycle pulse, CPU accepted the request
//   wake           any enabled source pending (ignores int_enable), HALT exit
//   busy           controller not idle
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int          NUM_SOURCES    = 6,
    parameter logic [11:0] VECTOR_BASE    = 12'h102,
    parameter int          VECTOR_STRIDE  = 2,
    parameter int          HOLDOFF_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] factor_flags,
    input  logic [NUM_SOURCES-1:0] irq_mask,
    input  logic                   int_enable,
    input  logic                   instr_boundary,
    output logic                   int_req,
    output logic [11:0]            int_vector,
    output logic [2:0]             int_source,
    input  logic                   int_ack,
    output logic                   wake,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        REQ     = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_int_req;
    logic [11:0]            r_int_vector;
    logic [2:0]             r_int_source;
    logic [3:0]             r_holdoff_cnt;

    logic [NUM_SOURCES-1:0] w_eligible;
    logic                   w_any_eligible;
    logic [2:0]             w_winner;
    logic [11:0]            w_vector;
    logic                   w_latched_eligible;
    logic                   w_load_grant;
    logic                   w_load_holdoff;

    assign w_eligible         = factor_flags & irq_mask;
    assign w_any_eligible     = |w_eligible;
    assign w_latched_eligible = w_eligible[r_int_source];

    // Lowest set index wins; scanning downwards lets the last hit be the winner.
    always_comb begin
        w_winner = 3'd0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    // Vector arithmetic is done at 12 bits so any carry out of the address
    // space is simply dropped.
    assign w_vector = VECTOR_BASE + (12'(VECTOR_STRIDE) * {9'd0, w_winner});

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. In REQ an ack always beats a cancel, and a newly
    // eligible higher-priority source never preempts the latched request.
    // If the flags vanish during the arbitration cycle there is nothing to
    // grant, so the controller falls back to IDLE instead of raising a
    // request that would cancel itself one cycle later.
    always_comb begin
        w_next_state   = r_state;
        w_load_grant   = 1'b0;
        w_load_holdoff = 1'b0;
        case (r_state)
            IDLE: begin
                if (int_enable && w_any_eligible && instr_boundary) begin
                    w_next_state = ARB;
                end
            end
            ARB: begin
                if (w_any_eligible) begin
                    w_next_state = REQ;
                    w_load_grant = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_next_state   = HOLDOFF;
                    w_load_holdoff = 1'b1;
                end else if (!int_enable || !w_latched_eligible) begin
                    w_next_state = IDLE;
                end
            end
            HOLDOFF: begin
                if (r_holdoff_cnt <= 4'd1) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request, vector and source registers. The vector and source only load
    // on a grant, so they stay stable for the whole request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_int_req    <= 1'b0;
            r_int_vector <= 12'd0;
            r_int_source <= 3'd0;
        end else begin
            r_int_req <= (w_next_state == REQ);
            if (w_load_grant) begin
                r_int_vector <= w_vector;
                r_int_source <= w_winner;
            end
        end
    end

    // Holdoff counter: loaded on ack and counted down so that the quiet
    // window lasts exactly HOLDOFF_CYCLES cycles; it reads 0 on return to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_holdoff_cnt <= 4'd0;
        end else if (w_load_holdoff) begin
            r_holdoff_cnt <= 4'(HOLDOFF_CYCLES);
        end else if (r_state == HOLDOFF && r_holdoff_cnt != 4'd0) begin
            r_holdoff_cnt <= r_holdoff_cnt - 4'd1;
        end
    end

    assign int_req    = r_int_req;
    assign int_vector = r_int_vector;
    assign int_source = r_int_source;
    assign wake       = w_any_eligible;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Self-checking bench for interrupt_controller: a table of single-request
// vectors, hand-written multi-cycle sequences (latency, masking, cancel,
// no preemption, async reset) and a long randomized run, all compared
// against a behavioural model of the request/holdoff rules.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  factorFlags;
    logic [5:0]  irqMask;
    logic        intEnable;
    logic        instrBoundary;
    logic        intAck;
    logic        intReq;
    logic [11:0] intVector;
    logic [2:0]  intSource;
    logic        wake;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: a pending grant, a live request with its source, and
    // the number of quiet cycles left after an ack.
    bit mArb;
    bit mReq;
    int mSrc;
    int mQuiet;

    typedef struct {
        logic [5:0]  ff;
        logic [5:0]  mask;
        logic        expWake;
        logic        expReq;
        logic [2:0]  expSrc;
        logic [11:0] expVec;
    } vec_t;

    vec_t vecs[9];

    interrupt_controller #(
        .NUM_SOURCES   (6),
        .VECTOR_BASE   (12'h102),
        .VECTOR_STRIDE (2),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .factor_flags  (factorFlags),
        .irq_mask      (irqMask),
        .int_enable    (intEnable),
        .instr_boundary(instrBoundary),
        .int_req       (intReq),
        .int_vector    (intVector),
        .int_source    (intSource),
        .int_ack       (intAck),
        .wake          (wake),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic int lowestSet(input logic [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] vecOf(input int s);
        return 32'(12'(32'h102 + 2 * s));
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        mArb   = 1'b0;
        mReq   = 1'b0;
        mSrc   = 0;
        mQuiet = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        logic [5:0] el;
        el = factorFlags & irqMask;
        if (mQuiet > 0) begin
            mQuiet--;
        end else if (mReq) begin
            if (intAck) begin
                mReq   = 1'b0;
                mQuiet = HOLD;
            end else if (!intEnable || !el[mSrc]) begin
                mReq = 1'b0;
            end
        end else if (mArb) begin
            mArb = 1'b0;
            if (el != 6'd0) begin
                mReq = 1'b1;
                mSrc = lowestSet(el);
            end
        end else if (intEnable && instrBoundary && el != 6'd0) begin
            mArb = 1'b1;
        end
    endtask

    task automatic checkOutput();
        compare("int_req", 32'(intReq), 32'(mReq));
        compare("busy", 32'(busy), 32'(mReq || mArb || mQuiet > 0));
        if (mReq) begin
            compare("int_source", 32'(intSource), 32'(mSrc));
            compare("int_vector", 32'(intVector), vecOf(mSrc));
        end
    endtask

    task automatic applyStimulus(input logic [5:0] ff, input logic [5:0] mask,
                                 input logic ie, input logic ib, input logic ack);
        factorFlags   = ff;
        irqMask       = mask;
        intEnable     = ie;
        instrBoundary = ib;
        intAck        = ack;
        #1;
        compare("wake", 32'(wake), 32'(|(ff & mask)));
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // From IDLE, pulse instr_boundary and wait until the request is raised.
    task automatic getRequest(input logic [5:0] ff);
        applyStimulus(ff, 6'h3F, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(ff, 6'h3F, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    // Ack the live request with flags cleared and wait out the holdoff.
    task automatic drain();
        applyStimulus(6'd0, 6'h3F, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(6'd0, 6'h3F, 1'b1, 1'b0, 1'b0);
        repeat (HOLD + 1) tick();
        compare("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [5:0] randFlags;
        logic [5:0] randMask;

        vecs[0] = '{6'b000100, 6'b111111, 1'b1, 1'b1, 3'd2, 12'h106};
        vecs[1] = '{6'b101010, 6'b111111, 1'b1, 1'b1, 3'd1, 12'h104};
        vecs[2] = '{6'b000001, 6'b000000, 1'b0, 1'b0, 3'd0, 12'h000};
        vecs[3] = '{6'b111111, 6'b111110, 1'b1, 1'b1, 3'd1, 12'h104};
        vecs[4] = '{6'b100000, 6'b111111, 1'b1, 1'b1, 3'd5, 12'h10C};
        vecs[5] = '{6'b000001, 6'b111111, 1'b1, 1'b1, 3'd0, 12'h102};
        vecs[6] = '{6'b110000, 6'b011111, 1'b1, 1'b1, 3'd4, 12'h10A};
        vecs[7] = '{6'b001000, 6'b110111, 1'b0, 1'b0, 3'd0, 12'h000};
        vecs[8] = '{6'b011000, 6'b110111, 1'b1, 1'b1, 3'd4, 12'h10A};

        // Reset state.
        reset_n       = 1'b0;
        factorFlags   = 6'd0;
        irqMask       = 6'd0;
        intEnable     = 1'b0;
        instrBoundary = 1'b0;
        intAck        = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #2;
        compare("rst_int_req", 32'(intReq), 32'd0);
        compare("rst_int_vector", 32'(intVector), 32'd0);
        compare("rst_int_source", 32'(intSource), 32'd0);
        compare("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Table-driven single requests.
        for (int k = 0; k < $size(vecs); k++) begin
            applyStimulus(vecs[k].ff, vecs[k].mask, 1'b1, 1'b0, 1'b0);
            compare("tbl_wake", 32'(wake), 32'(vecs[k].expWake));
            applyStimulus(vecs[k].ff, vecs[k].mask, 1'b1, 1'b1, 1'b0);
            tick();
            applyStimulus(vecs[k].ff, vecs[k].mask, 1'b1, 1'b0, 1'b0);
            tick();
            compare("tbl_req", 32'(intReq), 32'(vecs[k].expReq));
            if (vecs[k].expReq) begin
                compare("tbl_src", 32'(intSource), 32'(vecs[k].expSrc));
                compare("tbl_vec", 32'(intVector), 32'(vecs[k].expVec));
            end
            applyStimulus(vecs[k].ff, vecs[k].mask, 1'b1, 1'b0, 1'b1);
            tick();
            applyStimulus(6'd0, vecs[k].mask, 1'b1, 1'b0, 1'b0);
            repeat (HOLD + 1) tick();
            compare("tbl_idle", 32'(busy), 32'd0);
        end

        // Single source latency and holdoff length.
        applyStimulus(6'b000100, 6'h3F, 1'b1, 1'b1, 1'b0);
        tick();
        compare("lat_n1_req", 32'(intReq), 32'd0);
        compare("lat_n1_busy", 32'(busy), 32'd1);
        applyStimulus(6'b000100, 6'h3F, 1'b1, 1'b0, 1'b0);
        tick();
        compare("lat_n2_req", 32'(intReq), 32'd1);
        compare("lat_n2_src", 32'(intSource), 32'd2);
        compare("lat_n2_vec", 32'(intVector), 32'h106);
        tick();
        compare("lat_hold_req", 32'(intReq), 32'd1);
        applyStimulus(6'b000100, 6'h3F, 1'b1, 1'b0, 1'b1);
        tick();
        compare("ack_drop_req", 32'(intReq), 32'd0);
        applyStimulus(6'b000100, 6'h3F, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < HOLD - 1; c++) begin
            tick();
            compare("holdoff_busy", 32'(busy), 32'd1);
        end
        tick();
        compare("holdoff_end", 32'(busy), 32'd0);
        applyStimulus(6'd0, 6'h3F, 1'b1, 1'b0, 1'b0);
        tick();

        // Priority follow-up: after serving source 1, source 3 is next.
        getRequest(6'b101010);
        compare("prio_src1", 32'(intSource), 32'd1);
        applyStimulus(6'b101010, 6'h3F, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(6'b101000, 6'h3F, 1'b1, 1'b0, 1'b0);
        repeat (HOLD) tick();
        compare("prio_idle", 32'(busy), 32'd0);
        getRequest(6'b101000);
        compare("prio_src3", 32'(intSource), 32'd3);
        compare("prio_vec3", 32'(intVector), 32'h108);
        drain();

        // Masking and wake.
        applyStimulus(6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0);
        compare("mask_wake0", 32'(wake), 32'd0);
        applyStimulus(6'b000001, 6'b000000, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            compare("mask_noreq", 32'(intReq), 32'd0);
        end
        applyStimulus(6'b000001, 6'b000001, 1'b0, 1'b0, 1'b0);
        compare("ie0_wake1", 32'(wake), 32'd1);
        for (int c = 0; c < 50; c++) begin
            applyStimulus(6'b000001, 6'b000001, 1'b0, 1'(c % 5 == 0), 1'b0);
            tick();
            compare("ie0_noreq", 32'(intReq), 32'd0);
        end

        // Cancel by int_enable drop: straight back to IDLE.
        applyStimulus(6'd0, 6'h3F, 1'b1, 1'b0, 1'b0);
        tick();
        getRequest(6'b000100);
        applyStimulus(6'b000100, 6'h3F, 1'b0, 1'b0, 1'b0);
        tick();
        compare("cancel_req", 32'(intReq), 32'd0);
        compare("cancel_busy", 32'(busy), 32'd0);

        // Ack and int_enable drop together: ack wins, holdoff entered.
        getRequest(6'b000100);
        applyStimulus(6'b000100, 6'h3F, 1'b0, 1'b0, 1'b1);
        tick();
        compare("ackwin_req", 32'(intReq), 32'd0);
        compare("ackwin_busy", 32'(busy), 32'd1);
        applyStimulus(6'd0, 6'h3F, 1'b1, 1'b0, 1'b0);
        repeat (HOLD) tick();
        compare("ackwin_idle", 32'(busy), 32'd0);

        // No preemption; boundary during holdoff is ignored.
        getRequest(6'b010000);
        applyStimulus(6'b010001, 6'h3F, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            compare("nopre_src", 32'(intSource), 32'd4);
        end
        applyStimulus(6'b010001, 6'h3F, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(6'b010001, 6'h3F, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(6'b010001, 6'h3F, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            compare("hold_ib_ignored", 32'(intReq), 32'd0);
        end
        compare("nopre_idle", 32'(busy), 32'd0);
        getRequest(6'b010001);
        compare("nopre_src0", 32'(intSource), 32'd0);
        compare("nopre_vec0", 32'(intVector), 32'h102);
        drain();

        // Async reset between edges in the middle of a request.
        getRequest(6'b000100);
        #2;
        reset_n = 1'b0;
        #1;
        compare("arst_req", 32'(intReq), 32'd0);
        compare("arst_vec", 32'(intVector), 32'd0);
        compare("arst_busy", 32'(busy), 32'd0);
        resetModel();
        #1;
        reset_n = 1'b1;
        applyStimulus(6'b000100, 6'h3F, 1'b1, 1'b1, 1'b0);
        tick();
        compare("arst_n1_req", 32'(intReq), 32'd0);
        applyStimulus(6'b000100, 6'h3F, 1'b1, 1'b0, 1'b0);
        tick();
        compare("arst_n2_req", 32'(intReq), 32'd1);
        compare("arst_n2_src", 32'(intSource), 32'd2);
        drain();

        // Randomized traffic against the model.
        randFlags = 6'd0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) randFlags = 6'($urandom & $urandom);
            randMask = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h3F;
            applyStimulus(randFlags, randMask, 1'($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
